// File: rtl/tag_allocator_pkg.sv
// Shared types for the physical tag allocator: tag/sequence-number widths,
// the immediate-operand tag and the per-tag lifecycle state.
package tag_allocator_pkg;

  localparam int NUM_TAGS = 64;
  localparam int TAG_SIZE = $clog2(NUM_TAGS) + 1;
  localparam int SQN_SIZE = 7;

  typedef logic [TAG_SIZE-1:0] Tag;
  typedef logic [SQN_SIZE-1:0] SqN;

  // MSB set marks an immediate / constant-zero operand, never a physical tag
  localparam Tag TAG_ZERO = Tag'(NUM_TAGS);

  typedef enum logic [1:0] {
    TAG_FREE      = 2'd0,
    TAG_SPEC      = 2'd1,
    TAG_COMMITTED = 2'd2
  } tag_state_e;

  // True when sequence number a is strictly younger than b, using the
  // modular difference so the comparison survives SqN wrap-around.
  function automatic logic sqn_younger(SqN a, SqN b);
    SqN diff;
    diff = a - b;
    return !diff[SQN_SIZE-1] && (diff != '0);
  endfunction

endpackage

// File: rtl/tag_allocator_priority_encoder.sv
// Returns the indices of the NUM_OUT lowest set bits of req, lowest first.
// valid[k] is low when fewer than k+1 bits are set; idx[k] is then 0.
module PriorityEncoder #(
  parameter int WIDTH   = 64,
  parameter int NUM_OUT = 4,
  parameter int IDX_W   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   req,
  output logic [IDX_W-1:0]   idx [NUM_OUT],
  output logic [NUM_OUT-1:0] valid
);

  logic [WIDTH-1:0] remaining;

  // Peel off the lowest remaining set bit once per output slot
  always_comb begin
    remaining = req;
    for (int k = 0; k < NUM_OUT; k++) begin
      idx[k]   = '0;
      valid[k] = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!valid[k] && remaining[i]) begin
          idx[k]   = IDX_W'(i);
          valid[k] = 1'b1;
        end
      end
      if (valid[k]) remaining[idx[k]] = 1'b0;
    end
  end

endmodule

// File: rtl/tag_allocator.sv
// Physical tag allocator. Each tag is FREE, SPEC (allocated, not yet
// committed) or COMMITTED. Allocation is all-or-nothing per cycle from the
// lowest-index FREE tags; commits promote the new tag and release the
// previous mapping; a mispredict squashes every SPEC tag younger than the
// mispredicting op. Freed tags become visible to allocation next cycle.
module tag_allocator
  import tag_allocator_pkg::*;
#(
  parameter int NUM_ALLOC  = 4,
  parameter int NUM_COMMIT = 4,
  parameter int NUM_TAGS   = tag_allocator_pkg::NUM_TAGS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IN_mispred,
  input  SqN                           IN_mispredSqN,
  input  logic [NUM_ALLOC-1:0]         IN_allocValid,
  input  SqN                           IN_allocSqN [NUM_ALLOC],
  output Tag                           OUT_allocTag [NUM_ALLOC],
  output logic                         OUT_allocReady,
  input  logic [NUM_COMMIT-1:0]        IN_commitValid,
  input  Tag                           IN_commitNewTag [NUM_COMMIT],
  input  Tag                           IN_commitPrevTag [NUM_COMMIT],
  output logic [$clog2(NUM_TAGS+1)-1:0] OUT_freeCount
);

  localparam int IDX_W = $clog2(NUM_TAGS);
  localparam int CNT_W = $clog2(NUM_TAGS+1);

  tag_state_e tag_state     [NUM_TAGS];
  tag_state_e tag_state_nxt [NUM_TAGS];
  SqN         tag_sqn       [NUM_TAGS];
  SqN         tag_sqn_nxt   [NUM_TAGS];

  logic [NUM_TAGS-1:0]  free_vec;
  logic [IDX_W-1:0]     enc_idx [NUM_ALLOC];
  logic [NUM_ALLOC-1:0] enc_valid;
  logic [CNT_W-1:0]     free_count_nxt;

  // FREE vector feeding the encoder, taken from registered state only
  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      free_vec[t] = (tag_state[t] == TAG_FREE);
    end
  end

  PriorityEncoder #(
    .WIDTH   (NUM_TAGS),
    .NUM_OUT (NUM_ALLOC),
    .IDX_W   (IDX_W)
  ) u_free_enc (
    .req   (free_vec),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Offered tags and readiness; last encoder slot valid means enough are FREE
  always_comb begin
    for (int k = 0; k < NUM_ALLOC; k++) begin
      OUT_allocTag[k] = Tag'(enc_idx[k]);
    end
    OUT_allocReady = enc_valid[NUM_ALLOC-1] && !IN_mispred;
  end

  // Next tag state: squash, then allocate, then commits (commit wins over squash)
  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      tag_state_nxt[t] = tag_state[t];
      tag_sqn_nxt[t]   = tag_sqn[t];
      if (IN_mispred && tag_state[t] == TAG_SPEC &&
          sqn_younger(tag_sqn[t], IN_mispredSqN)) begin
        tag_state_nxt[t] = TAG_FREE;
      end
    end

    if (OUT_allocReady) begin
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (IN_allocValid[k]) begin
          tag_state_nxt[enc_idx[k]] = TAG_SPEC;
          tag_sqn_nxt[enc_idx[k]]   = IN_allocSqN[k];
        end
      end
    end

    for (int c = 0; c < NUM_COMMIT; c++) begin
      if (IN_commitValid[c] && !IN_commitNewTag[c][TAG_SIZE-1]) begin
        tag_state_nxt[IN_commitNewTag[c][IDX_W-1:0]] = TAG_COMMITTED;
      end
      if (IN_commitValid[c] && !IN_commitPrevTag[c][TAG_SIZE-1]) begin
        tag_state_nxt[IN_commitPrevTag[c][IDX_W-1:0]] = TAG_FREE;
      end
    end
  end

  // Count of FREE tags after this cycle's updates
  always_comb begin
    free_count_nxt = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (tag_state_nxt[t] == TAG_FREE) free_count_nxt = free_count_nxt + CNT_W'(1);
    end
  end

  // State registers; reset overrides every input
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        tag_state[t] <= TAG_FREE;
        tag_sqn[t]   <= '0;
      end
      OUT_freeCount <= CNT_W'(NUM_TAGS);
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        tag_state[t] <= tag_state_nxt[t];
        tag_sqn[t]   <= tag_sqn_nxt[t];
      end
      OUT_freeCount <= free_count_nxt;
    end
  end

  function automatic logic live(logic v, Tag t);
    return v && !t[TAG_SIZE-1];
  endfunction

  // Protocol checks on commit traffic: legal transitions and no duplicate tags
  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_COMMIT; c++) begin
        if (live(IN_commitValid[c], IN_commitNewTag[c]))
          assert (tag_state[IN_commitNewTag[c][IDX_W-1:0]] == TAG_SPEC);
        if (live(IN_commitValid[c], IN_commitPrevTag[c]))
          assert (tag_state[IN_commitPrevTag[c][IDX_W-1:0]] == TAG_COMMITTED);
        for (int d = 0; d < NUM_COMMIT; d++) begin
          if (d > c) begin
            if (live(IN_commitValid[c], IN_commitNewTag[c]) &&
                live(IN_commitValid[d], IN_commitNewTag[d]))
              assert (IN_commitNewTag[c] != IN_commitNewTag[d]);
            if (live(IN_commitValid[c], IN_commitPrevTag[c]) &&
                live(IN_commitValid[d], IN_commitPrevTag[d]))
              assert (IN_commitPrevTag[c] != IN_commitPrevTag[d]);
          end
          if (live(IN_commitValid[c], IN_commitNewTag[c]) &&
              live(IN_commitValid[d], IN_commitPrevTag[d]))
            assert (IN_commitNewTag[c] != IN_commitPrevTag[d]);
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_allocator.sv
// Bench for tag_allocator: directed scenarios plus a random phase, checked
// against a per-tag reference model; expected free counts go through a queue.
module tb_tag_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       mispred;
  logic [6:0] msqn;
  logic [3:0] a_valid;
  logic [6:0] a_sqn [4];
  logic [6:0] a_tag [4];
  logic       a_ready;
  logic [3:0] c_valid;
  logic [6:0] c_new [4];
  logic [6:0] c_prev [4];
  logic [6:0] free_count;

  int n_tests = 0;
  int n_fail  = 0;
  int m_state [64];   // 0 FREE, 1 SPEC, 2 COMMITTED
  int m_sqn   [64];
  int fc_q [$];
  int seq = 0;

  tag_allocator dut (
    .clk              (clk),
    .rst              (rst),
    .IN_mispred       (mispred),
    .IN_mispredSqN    (msqn),
    .IN_allocValid    (a_valid),
    .IN_allocSqN      (a_sqn),
    .OUT_allocTag     (a_tag),
    .OUT_allocReady   (a_ready),
    .IN_commitValid   (c_valid),
    .IN_commitNewTag  (c_new),
    .IN_commitPrevTag (c_prev),
    .OUT_freeCount    (free_count)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    mispred = 1'b0;
    msqn    = '0;
    a_valid = '0;
    c_valid = '0;
    for (int k = 0; k < 4; k++) begin
      a_sqn[k]  = '0;
      c_new[k]  = 7'h40;
      c_prev[k] = 7'h40;
    end
  endtask

  // One cycle: check combinational outputs, advance model, check free count
  task automatic step();
    int nfree;
    int etag [4];
    int ns [64];
    int cnt;
    int d;
    bit eready;
    #1;
    nfree = 0;
    for (int t = 0; t < 64; t++) begin
      if (m_state[t] == 0) begin
        if (nfree < 4) etag[nfree] = t;
        nfree++;
      end
    end
    eready = (nfree >= 4) && !mispred;
    if (!rst) begin
      chk_eq("alloc_ready", int'(a_ready), int'(eready));
      for (int k = 0; k < 4; k++)
        if (k < nfree) chk_eq($sformatf("alloc_tag%0d", k), int'(a_tag[k]), etag[k]);
    end
    if (rst) begin
      for (int t = 0; t < 64; t++) begin ns[t] = 0; m_sqn[t] = 0; end
    end else begin
      for (int t = 0; t < 64; t++) begin
        ns[t] = m_state[t];
        d = (m_sqn[t] - int'(msqn)) & 127;
        if (mispred && m_state[t] == 1 && d != 0 && d < 64) ns[t] = 0;
      end
      if (eready)
        for (int k = 0; k < 4; k++)
          if (a_valid[k]) begin ns[etag[k]] = 1; m_sqn[etag[k]] = int'(a_sqn[k]); end
      for (int c = 0; c < 4; c++) begin
        if (c_valid[c] && !c_new[c][6])  ns[c_new[c][5:0]] = 2;
        if (c_valid[c] && !c_prev[c][6]) ns[c_prev[c][5:0]] = 0;
      end
    end
    cnt = 0;
    for (int t = 0; t < 64; t++) begin
      m_state[t] = ns[t];
      if (ns[t] == 0) cnt++;
    end
    fc_q.push_back(cnt);
    @(posedge clk);
    #1;
    chk_eq("free_count", int'(free_count), fc_q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_cycle(logic [3:0] mask, int base);
    clear_inputs();
    a_valid = mask;
    for (int k = 0; k < 4; k++) a_sqn[k] = 7'((base + k) & 127);
    step();
    clear_inputs();
  endtask

  task automatic commit1(logic [6:0] nt, logic [6:0] pt);
    clear_inputs();
    c_valid  = 4'b0001;
    c_new[0] = nt;
    c_prev[0] = pt;
    step();
    clear_inputs();
  endtask

  initial begin
    int s, nt, pt, slot;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // first grant and full allocation of all tags
    for (int i = 0; i < 16; i++) alloc_cycle(4'hF, 4 * i);
    alloc_cycle(4'hF, 64);
    step();

    // commit then release tag 5 via a later commit
    commit1(7'd5, 7'h40);
    step();
    commit1(7'd9, 7'd5);
    step();

    // mispredict with alloc request and commit of tag 3 in the same cycle
    clear_inputs();
    a_valid = 4'hF;
    mispred = 1'b1;
    msqn    = 7'd20;
    c_valid = 4'b0001;
    c_new[0] = 7'd3;
    step();
    clear_inputs();
    step();

    // SqN wrap-around squash
    do_reset();
    alloc_cycle(4'hF, 100);
    alloc_cycle(4'hF, 104);
    alloc_cycle(4'b0011, 108);
    clear_inputs();
    a_valid = 4'b0111;
    a_sqn[0] = 7'd126;
    a_sqn[1] = 7'd127;
    a_sqn[2] = 7'd1;
    step();
    clear_inputs();
    mispred = 1'b1;
    msqn    = 7'd127;
    step();
    clear_inputs();
    step();

    // reset mid-stream with 40 tags in use
    do_reset();
    for (int i = 0; i < 10; i++) alloc_cycle(4'hF, 4 * i);
    clear_inputs();
    rst = 1'b1;
    a_valid = 4'hF;
    step();
    rst = 1'b0;
    clear_inputs();
    step();

    // random traffic with legal commits
    seq = 0;
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      a_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) a_sqn[k] = 7'((seq + k) & 127);
      seq = seq + 4;
      if ($urandom_range(0, 7) == 0) begin
        mispred = 1'b1;
        msqn = 7'($urandom_range(0, 127));
      end
      nt = 64;
      pt = 64;
      if ($urandom_range(0, 2) != 0) begin
        s = $urandom_range(0, 63);
        for (int j = 0; j < 64; j++)
          if (nt == 64 && m_state[(s + j) % 64] == 1) nt = (s + j) % 64;
      end
      if ($urandom_range(0, 2) != 0) begin
        s = $urandom_range(0, 63);
        for (int j = 0; j < 64; j++)
          if (pt == 64 && m_state[(s + j) % 64] == 2) pt = (s + j) % 64;
      end
      slot = $urandom_range(0, 3);
      c_valid = 4'($urandom_range(0, 15));
      c_valid[slot] = 1'b1;
      c_new[slot]  = 7'(nt);
      c_prev[slot] = 7'(pt);
      step();
    end
    clear_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
